// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and codes for the D->E hazard scoreboard: forward-select
// codes, Tuse sentinel, scoreboard entry layout and small entry helpers.
package hazard_scoreboard_pkg;

  localparam int REG_W  = 5;
  localparam int TNEW_W = 2;
  localparam int TUSE_W = 2;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [REG_W-1:0]  a3;
    logic              we;
    logic [TNEW_W-1:0] tnew;
    logic              is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // Advance an entry by one stage: tnew counts down and sticks at zero.
  function automatic sb_entry_t sb_age(input sb_entry_t e);
    sb_entry_t r;
    r = e;
    if (e.tnew != '0) begin
      r.tnew = e.tnew - 1'b1;
    end
    return r;
  endfunction

  function automatic logic sb_hit(input sb_entry_t e, input logic [REG_W-1:0] addr);
    return e.we && (e.a3 == addr) && (addr != '0);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// Per-operand lookup: finds the nearest in-flight writer of addr and derives
// the stall request, load-origin flag and forward select from it.
module sb_match
  import hazard_scoreboard_pkg::*;
(
  input  logic [REG_W-1:0]  addr,
  input  logic [TUSE_W-1:0] tuse,
  input  sb_entry_t         ent_e,
  input  sb_entry_t         ent_m,
  input  sb_entry_t         ent_w,
  output logic              hit,
  output logic              stall,
  output logic              near_load,
  output logic [1:0]        fwd
);

  logic [TNEW_W-1:0] near_tnew;
  logic              near_is_load;
  logic [1:0]        near_src;

  // Priority E > M > W: a younger writer shadows every older one.
  always_comb begin
    hit          = 1'b0;
    near_tnew    = '0;
    near_is_load = 1'b0;
    near_src     = FWD_GRF;
    if (sb_hit(ent_e, addr)) begin
      hit          = 1'b1;
      near_tnew    = ent_e.tnew;
      near_is_load = ent_e.is_load;
      near_src     = FWD_E;
    end else if (sb_hit(ent_m, addr)) begin
      hit          = 1'b1;
      near_tnew    = ent_m.tnew;
      near_is_load = ent_m.is_load;
      near_src     = FWD_M;
    end else if (sb_hit(ent_w, addr)) begin
      hit          = 1'b1;
      near_tnew    = ent_w.tnew;
      near_is_load = ent_w.is_load;
      near_src     = FWD_W;
    end
  end

  always_comb begin
    stall     = hit && (tuse != TUSE_NONE) && (near_tnew > tuse);
    near_load = hit && near_is_load && (near_src != FWD_W);
    fwd       = (hit && (near_tnew == '0)) ? near_src : FWD_GRF;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/flush/forward controller for the D->E boundary: shadow scoreboard of
// in-flight writers in E/M/W plus a busy counter for the multiply/divide unit.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MDU_MUL_CYC = 5,
  parameter int MDU_DIV_CYC = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  d_rs,
  input  logic [REG_W-1:0]  d_rt,
  input  logic [TUSE_W-1:0] d_tuse_rs,
  input  logic [TUSE_W-1:0] d_tuse_rt,
  input  logic [REG_W-1:0]  d_a3,
  input  logic              d_we,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_is_load,
  input  logic              d_is_mdu,
  input  logic              e_mdu_start,
  input  logic              e_mdu_div,
  output logic              stall,
  output logic              e_clear,
  output logic              e_lwstall,
  output logic              mdu_busy,
  output logic [1:0]        fwd_rs,
  output logic [1:0]        fwd_rt
);

  localparam int MDU_MAX = (MDU_DIV_CYC > MDU_MUL_CYC) ? MDU_DIV_CYC : MDU_MUL_CYC;
  localparam int CNT_W   = $clog2(MDU_MAX + 1);

  sb_entry_t        sb_e_q, sb_e_d;
  sb_entry_t        sb_m_q, sb_m_d;
  sb_entry_t        sb_w_q, sb_w_d;
  logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;

  logic       rs_hit, rs_stall, rs_load;
  logic       rt_hit, rt_stall, rt_load;
  logic [1:0] rs_fwd, rt_fwd;
  logic       busy_int, data_stall, mdu_stall, stall_int, lw_int;

  sb_match u_match_rs (
    .addr      (d_rs),
    .tuse      (d_tuse_rs),
    .ent_e     (sb_e_q),
    .ent_m     (sb_m_q),
    .ent_w     (sb_w_q),
    .hit       (rs_hit),
    .stall     (rs_stall),
    .near_load (rs_load),
    .fwd       (rs_fwd)
  );

  sb_match u_match_rt (
    .addr      (d_rt),
    .tuse      (d_tuse_rt),
    .ent_e     (sb_e_q),
    .ent_m     (sb_m_q),
    .ent_w     (sb_w_q),
    .hit       (rt_hit),
    .stall     (rt_stall),
    .near_load (rt_load),
    .fwd       (rt_fwd)
  );

  always_comb begin
    busy_int   = (mdu_cnt_q != '0);
    data_stall = rs_stall | rt_stall;
    mdu_stall  = d_is_mdu && (busy_int || e_mdu_start);
    stall_int  = data_stall | mdu_stall;
    lw_int     = (rs_hit && rs_stall && rs_load) || (rt_hit && rt_stall && rt_load);
  end

  // A stalled D instruction must not enter E, so a bubble takes its slot.
  always_comb begin
    sb_w_d = sb_age(sb_m_q);
    sb_m_d = sb_age(sb_e_q);
    if (stall_int) begin
      sb_e_d = SB_BUBBLE;
    end else begin
      sb_e_d = '{a3: d_a3, we: d_we, tnew: d_tnew, is_load: d_is_load};
    end
  end

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (e_mdu_start) begin
      mdu_cnt_d = e_mdu_div ? CNT_W'(MDU_DIV_CYC) : CNT_W'(MDU_MUL_CYC);
    end else if (mdu_cnt_q != '0) begin
      mdu_cnt_d = mdu_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_e_q    <= SB_BUBBLE;
      sb_m_q    <= SB_BUBBLE;
      sb_w_q    <= SB_BUBBLE;
      mdu_cnt_q <= '0;
    end else begin
      sb_e_q    <= sb_e_d;
      sb_m_q    <= sb_m_d;
      sb_w_q    <= sb_w_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is held, even if D/E inputs are live.
  always_comb begin
    stall     = reset & stall_int;
    e_clear   = reset & stall_int;
    e_lwstall = reset & lw_int;
    mdu_busy  = reset & busy_int;
    fwd_rs    = reset ? rs_fwd : FWD_GRF;
    fwd_rt    = reset ? rt_fwd : FWD_GRF;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table plus hand-written
// MDU and reset sequences, expectations queued and compared per cycle.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_we, d_is_load, d_is_mdu, e_mdu_start, e_mdu_div;
  logic       stall, e_clear, e_lwstall, mdu_busy;
  logic [1:0] fwd_rs, fwd_rt;

  hazard_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_tuse_rs   (d_tuse_rs),
    .d_tuse_rt   (d_tuse_rt),
    .d_a3        (d_a3),
    .d_we        (d_we),
    .d_tnew      (d_tnew),
    .d_is_load   (d_is_load),
    .d_is_mdu    (d_is_mdu),
    .e_mdu_start (e_mdu_start),
    .e_mdu_div   (e_mdu_div),
    .stall       (stall),
    .e_clear     (e_clear),
    .e_lwstall   (e_lwstall),
    .mdu_busy    (mdu_busy),
    .fwd_rs      (fwd_rs),
    .fwd_rt      (fwd_rt)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] trs, trt;
    logic [4:0] a3;
    logic       we;
    logic [1:0] tnew;
    logic       ld;
    logic       x_st, x_lw;
    logic [1:0] x_frs, x_frt;
  } vec_t;

  typedef struct {
    string      tag;
    logic       st, lw, busy;
    logic [1:0] frs, frt;
  } exp_t;

  exp_t exp_q[$];
  vec_t vt[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic [1:0] trs, input logic [1:0] trt,
                              input logic [4:0] a3, input logic we,
                              input logic [1:0] tnew, input logic ld,
                              input logic st, input logic lw,
                              input logic [1:0] frs, input logic [1:0] frt);
    vec_t v;
    v.rs = rs; v.rt = rt; v.trs = trs; v.trt = trt;
    v.a3 = a3; v.we = we; v.tnew = tnew; v.ld = ld;
    v.x_st = st; v.x_lw = lw; v.x_frs = frs; v.x_frt = frt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] trs, input logic [1:0] trt,
                       input logic [4:0] a3, input logic we, input logic [1:0] tnew,
                       input logic ld, input logic mdu, input logic ms, input logic md);
    d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
    d_a3 = a3; d_we = we; d_tnew = tnew; d_is_load = ld;
    d_is_mdu = mdu; e_mdu_start = ms; e_mdu_div = md;
  endtask

  task automatic expect_out(input string tag, input logic st, input logic lw,
                            input logic busy, input logic [1:0] frs, input logic [1:0] frt);
    exp_t e;
    e.tag = tag; e.st = st; e.lw = lw; e.busy = busy; e.frs = frs; e.frt = frt;
    exp_q.push_back(e);
  endtask

  task automatic check_outputs();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL queue_empty actual=0 required=1");
      return;
    end
    e = exp_q.pop_front();
    $display("txn %s stall=%0d clr=%0d lw=%0d busy=%0d frs=%0d frt=%0d",
             e.tag, stall, e_clear, e_lwstall, mdu_busy, fwd_rs, fwd_rt);
    chk({e.tag, ".stall"},   {3'b0, stall},     {3'b0, e.st});
    chk({e.tag, ".e_clear"}, {3'b0, e_clear},   {3'b0, e.st});
    chk({e.tag, ".lwstall"}, {3'b0, e_lwstall}, {3'b0, e.lw});
    chk({e.tag, ".busy"},    {3'b0, mdu_busy},  {3'b0, e.busy});
    chk({e.tag, ".fwd_rs"},  {2'b0, fwd_rs},    {2'b0, e.frs});
    chk({e.tag, ".fwd_rt"},  {2'b0, fwd_rt},    {2'b0, e.frt});
  endtask

  task automatic next_cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rs, rt, tuse_rs, tuse_rt, a3, we, tnew, load -> stall, lw, fwd_rs, fwd_rt
    vt.push_back(mk( 0, 0, 3, 3,  1, 1, 2, 1,  0, 0, 0, 0));  // lw $1
    vt.push_back(mk( 1, 3, 1, 1,  2, 1, 1, 0,  1, 1, 0, 0));  // addu $2,$1,$3 load-use
    vt.push_back(mk( 1, 3, 1, 1,  2, 1, 1, 0,  0, 0, 0, 0));  // M tnew=1: no fwd yet
    vt.push_back(mk( 1, 2, 1, 1,  4, 1, 1, 0,  0, 0, 3, 0));  // $1 from W
    vt.push_back(mk( 2, 4, 0, 0,  0, 0, 0, 0,  1, 0, 2, 0));  // non-load stall on rt
    vt.push_back(mk( 4, 2, 3, 3,  0, 0, 0, 0,  0, 0, 2, 3));  // tuse=3 still forwards
    vt.push_back(mk( 0, 0, 3, 3,  0, 0, 0, 0,  0, 0, 0, 0));
    vt.push_back(mk( 0, 0, 3, 3,  1, 1, 1, 0,  0, 0, 0, 0));  // addu $1
    vt.push_back(mk( 1, 5, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0));  // beq $1 stalls
    vt.push_back(mk( 1, 5, 0, 0,  0, 0, 0, 0,  0, 0, 2, 0));  // then from M
    vt.push_back(mk( 0, 0, 3, 3,  0, 0, 0, 0,  0, 0, 0, 0));
    vt.push_back(mk( 0, 0, 3, 3, 31, 1, 0, 0,  0, 0, 0, 0));  // jal
    vt.push_back(mk(31, 0, 0, 3,  0, 0, 0, 0,  0, 0, 1, 0));  // jr $31 from E
    vt.push_back(mk(31, 0, 0, 3,  0, 1, 2, 1,  0, 0, 2, 0));  // writer of $0
    vt.push_back(mk(31, 0, 0, 0,  0, 1, 2, 1,  0, 0, 3, 0));  // $0 never matches; W tnew stays 0
    vt.push_back(mk( 0, 0, 3, 3,  7, 1, 2, 1,  0, 0, 0, 0));  // lw $7
    vt.push_back(mk( 0, 0, 3, 3,  7, 1, 0, 0,  0, 0, 0, 0));  // newer $7, tnew=0
    vt.push_back(mk( 7, 7, 0, 0,  0, 0, 0, 0,  0, 0, 1, 1));  // older load shadowed
    vt.push_back(mk( 0, 0, 3, 3,  8, 1, 2, 1,  0, 0, 0, 0));  // lw $8
    vt.push_back(mk( 0, 0, 3, 3,  0, 0, 0, 0,  0, 0, 0, 0));
    vt.push_back(mk( 8, 0, 0, 3,  0, 0, 0, 0,  1, 1, 0, 0));  // load in M stalls
    vt.push_back(mk( 8, 0, 0, 3,  0, 0, 0, 0,  0, 0, 3, 0));
    vt.push_back(mk( 0, 0, 3, 3,  9, 1, 3, 1,  0, 0, 0, 0));  // tnew=3 load
    vt.push_back(mk( 9, 0, 3, 3,  0, 0, 0, 0,  0, 0, 0, 0));  // tuse=3 never stalls
    vt.push_back(mk( 0, 0, 3, 3,  0, 0, 0, 0,  0, 0, 0, 0));
    vt.push_back(mk( 9, 0, 0, 3,  0, 0, 0, 0,  1, 0, 0, 0));  // W tnew=1: stall, not lw
    vt.push_back(mk( 9, 0, 0, 3,  0, 0, 0, 0,  0, 0, 0, 0));

    // Reset state, with live MDU inputs that must be masked.
    reset = 1'b0;
    drive(0, 0, 3, 3, 0, 0, 0, 0, 1, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0, 0);
    check_outputs();
    drive(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rs, vt[i].rt, vt[i].trs, vt[i].trt, vt[i].a3, vt[i].we,
            vt[i].tnew, vt[i].ld, 0, 0, 0);
      expect_out($sformatf("vec%0d", i), vt[i].x_st, vt[i].x_lw, 0, vt[i].x_frs, vt[i].x_frt);
      next_cycle();
    end

    // Divide start with mflo waiting in D.
    for (int k = 0; k <= 11; k++) begin
      drive(0, 0, 3, 3, 0, 0, 0, 0, 1, (k == 0), 1);
      expect_out($sformatf("div%0d", k), (k <= 10), 0, (k >= 1 && k <= 10), 0, 0);
      next_cycle();
    end

    // Divide, then a multiply restart on cycle 4; consumer arrives from cycle 6.
    for (int k = 0; k <= 10; k++) begin
      drive(0, 0, 3, 3, 0, 0, 0, 0, (k >= 6), (k == 0 || k == 4), (k == 0));
      expect_out($sformatf("rst_mdu%0d", k), (k >= 6 && k <= 9), 0, (k >= 1 && k <= 9), 0, 0);
      next_cycle();
    end

    // Asynchronous reset with a tnew=2 load in E and the MDU busy.
    drive(0, 0, 3, 3, 1, 1, 2, 1, 0, 1, 1);
    expect_out("pre_lw", 0, 0, 0, 0, 0);
    next_cycle();
    drive(1, 0, 1, 3, 2, 1, 1, 0, 1, 0, 0);
    #1;
    expect_out("pre_rst", 1, 1, 1, 0, 0);
    check_outputs();
    reset = 1'b0;
    #1;
    expect_out("in_rst", 0, 0, 0, 0, 0);
    check_outputs();
    @(posedge clk);
    #1;
    drive(1, 0, 1, 3, 2, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    expect_out("post_rel", 0, 0, 0, 0, 0);
    check_outputs();
    @(posedge clk);
    #1;
    drive(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    expect_out("post_edge", 0, 0, 0, 0, 0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
